// File: rtl/stage_sequencer.sv
// stage_sequencer
// Central control sequencer for the single-issue LEGv8 datapath. Steps each
// instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. Each stage
// is held for a parameterised number of cycles. A one-cycle enable strobe is
// issued on the last cycle of each stage.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_start         begin execution from IDLE
//   i_single_step   return to IDLE after each retired instruction
//   i_halt_req      stop after the current instruction (or at once from IDLE)
//   i_mem_ready     data memory done; MEMORY is extended while low
//   o_fetch_en      strobe, last FETCH cycle
//   o_decode_en     strobe, last DECODE cycle
//   o_exec_en       strobe, last EXECUTE cycle
//   o_mem_en        level, every MEMORY cycle
//   o_wb_en         strobe, last WRITEBACK cycle
//   o_pc_write      strobe, coincident with o_wb_en
//   o_busy          high in FETCH..WRITEBACK
//   o_halted        high in HALT
//   o_state         IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//   o_instr_count   retired instruction count (wraps)
module stage_sequencer #(
    parameter int unsigned FETCH_CYCLES  = 2,
    parameter int unsigned DECODE_CYCLES = 1,
    parameter int unsigned EXEC_CYCLES   = 1,
    parameter int unsigned MEM_CYCLES    = 1,
    parameter int unsigned WB_CYCLES     = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_single_step,
    input  logic        i_halt_req,
    input  logic        i_mem_ready,
    output logic        o_fetch_en,
    output logic        o_decode_en,
    output logic        o_exec_en,
    output logic        o_mem_en,
    output logic        o_wb_en,
    output logic        o_pc_write,
    output logic        o_busy,
    output logic        o_halted,
    output logic [2:0]  o_state,
    output logic [31:0] o_instr_count
);

    // Counter value of a stage's final cycle; 0 cycles behaves as 1 and the
    // 4-bit counter caps the stage length at 15.
    function automatic logic [3:0] last_cnt(input int unsigned n);
        if (n == 0) begin
            return 4'd0;
        end else if (n > 15) begin
            return 4'd14;
        end else begin
            return 4'(n - 1);
        end
    endfunction

    localparam logic [3:0] FETCH_LAST  = last_cnt(FETCH_CYCLES);
    localparam logic [3:0] DECODE_LAST = last_cnt(DECODE_CYCLES);
    localparam logic [3:0] EXEC_LAST   = last_cnt(EXEC_CYCLES);
    localparam logic [3:0] MEM_LAST    = last_cnt(MEM_CYCLES);
    localparam logic [3:0] WB_LAST     = last_cnt(WB_CYCLES);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_d;
    logic        r_halt_pending;
    logic        w_halt_pending_d;
    logic [31:0] r_instr_count;
    logic [31:0] w_instr_count_d;
    logic        w_busy_now;

    // Registered output images, computed from the next state so that every
    // output lines up with the state it describes.
    logic r_fetch_en, r_decode_en, r_exec_en, r_mem_en, r_wb_en, r_busy, r_halted;
    logic w_fetch_en_d, w_decode_en_d, w_exec_en_d, w_mem_en_d, w_wb_en_d;
    logic w_busy_d, w_halted_d;

    // Next-state logic
    always_comb begin
        w_state_d        = r_state;
        w_cnt_d          = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
        w_halt_pending_d = r_halt_pending;
        w_instr_count_d  = r_instr_count;
        w_busy_now       = (r_state == StFetch) || (r_state == StDecode) ||
                           (r_state == StExec)  || (r_state == StMem)    ||
                           (r_state == StWb);

        if (w_busy_now && i_halt_req) begin
            w_halt_pending_d = 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                w_cnt_d = 4'd0;
                // Halt wins over start when both arrive together.
                if (i_halt_req) begin
                    w_state_d = StHalt;
                end else if (i_start) begin
                    w_state_d = StFetch;
                end
            end
            StFetch: begin
                if (r_cnt == FETCH_LAST) begin
                    w_state_d = StDecode;
                    w_cnt_d   = 4'd0;
                end
            end
            StDecode: begin
                if (r_cnt == DECODE_LAST) begin
                    w_state_d = StExec;
                    w_cnt_d   = 4'd0;
                end
            end
            StExec: begin
                if (r_cnt == EXEC_LAST) begin
                    w_state_d = StMem;
                    w_cnt_d   = 4'd0;
                end
            end
            StMem: begin
                // Minimum length reached and memory done on the same cycle.
                if ((r_cnt >= MEM_LAST) && i_mem_ready) begin
                    w_state_d = StWb;
                    w_cnt_d   = 4'd0;
                end
            end
            StWb: begin
                if (r_cnt == WB_LAST) begin
                    w_instr_count_d  = r_instr_count + 32'd1;
                    w_cnt_d          = 4'd0;
                    w_halt_pending_d = 1'b0;
                    if (r_halt_pending || i_halt_req) begin
                        w_state_d = StHalt;
                    end else if (i_single_step) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                w_cnt_d = 4'd0;
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = 4'd0;
            end
        endcase
    end

    // Output images of the next state
    always_comb begin
        w_fetch_en_d  = (w_state_d == StFetch)  && (w_cnt_d == FETCH_LAST);
        w_decode_en_d = (w_state_d == StDecode) && (w_cnt_d == DECODE_LAST);
        w_exec_en_d   = (w_state_d == StExec)   && (w_cnt_d == EXEC_LAST);
        w_mem_en_d    = (w_state_d == StMem);
        w_wb_en_d     = (w_state_d == StWb)     && (w_cnt_d == WB_LAST);
        w_busy_d      = (w_state_d == StFetch) || (w_state_d == StDecode) ||
                        (w_state_d == StExec)  || (w_state_d == StMem)    ||
                        (w_state_d == StWb);
        w_halted_d    = (w_state_d == StHalt);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= StIdle;
            r_cnt          <= 4'd0;
            r_halt_pending <= 1'b0;
            r_instr_count  <= 32'd0;
            r_fetch_en     <= 1'b0;
            r_decode_en    <= 1'b0;
            r_exec_en      <= 1'b0;
            r_mem_en       <= 1'b0;
            r_wb_en        <= 1'b0;
            r_busy         <= 1'b0;
            r_halted       <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_cnt          <= w_cnt_d;
            r_halt_pending <= w_halt_pending_d;
            r_instr_count  <= w_instr_count_d;
            r_fetch_en     <= w_fetch_en_d;
            r_decode_en    <= w_decode_en_d;
            r_exec_en      <= w_exec_en_d;
            r_mem_en       <= w_mem_en_d;
            r_wb_en        <= w_wb_en_d;
            r_busy         <= w_busy_d;
            r_halted       <= w_halted_d;
        end
    end

    assign o_fetch_en    = r_fetch_en;
    assign o_decode_en   = r_decode_en;
    assign o_exec_en     = r_exec_en;
    assign o_mem_en      = r_mem_en;
    assign o_wb_en       = r_wb_en;
    assign o_pc_write    = r_wb_en;
    assign o_busy        = r_busy;
    assign o_halted      = r_halted;
    assign o_state       = r_state;
    assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: scoreboard of expected retirements (cycle and
// count) pushed when start is driven and popped whenever wb_en is observed.
module tb_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, single_step, halt_req, mem_ready;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en, pc_write, busy, halted;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic [4:0]  strobes;

    always #5 clk = ~clk;

    stage_sequencer dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_single_step (single_step),
        .i_halt_req    (halt_req),
        .i_mem_ready   (mem_ready),
        .o_fetch_en    (fetch_en),
        .o_decode_en   (decode_en),
        .o_exec_en     (exec_en),
        .o_mem_en      (mem_en),
        .o_wb_en       (wb_en),
        .o_pc_write    (pc_write),
        .o_busy        (busy),
        .o_halted      (halted),
        .o_state       (state),
        .o_instr_count (instr_count)
    );

    assign strobes = {fetch_en, decode_en, exec_en, mem_en, wb_en};

    typedef struct {
        int          cyc;
        int unsigned cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks   = 0;
    int          n_pass     = 0;
    int          cyc        = 0;
    int          mem_cycles = 0;
    bit          pend       = 1'b0;
    int unsigned pend_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, run the retirement monitor.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("strobe_overlap",
            32'(($countones({fetch_en, decode_en, exec_en, wb_en}) <= 1) ? 1 : 0), 32'd1);
        chk("pc_write_eq_wb", 32'(pc_write), 32'(wb_en));
        if (pend) begin
            chk("count_after_wb", instr_count, pend_cnt);
            pend = 1'b0;
        end
        if (mem_en) mem_cycles++;
        if (wb_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_cycle", 32'(cyc), 32'(e.cyc));
                chk("count_at_wb", instr_count, e.cnt - 1);
                pend     = 1'b1;
                pend_cnt = e.cnt;
            end
        end
    endtask

    task automatic pulse_start(output int e);
        start = 1'b1;
        step();
        start = 1'b0;
        e = cyc;
    endtask

    logic [4:0] t1_strb [7] = '{5'b00000, 5'b10000, 5'b01000, 5'b00100,
                                5'b00010, 5'b00001, 5'b00000};
    int         t1_state [7] = '{1, 1, 2, 3, 4, 5, 1};

    initial begin
        int e;
        int budget;
        reset       = 1'b1;
        start       = 1'b1;
        single_step = 1'b0;
        halt_req    = 1'b0;
        mem_ready   = 1'b1;

        // Reset held three cycles with start high
        repeat (3) step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outputs", 32'({strobes, pc_write, busy, halted}), 32'd0);
        chk("rst_count", instr_count, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        step();
        chk("idle_after_rst", 32'(state), 32'd0);

        // First instruction traced stage by stage, then free run of 10
        pulse_start(e);
        for (int k = 0; k < 10; k++) sb.push_back('{e + 5 + 6 * k, 32'(k + 1)});
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            chk($sformatf("t1_state_%0d", k), 32'(state), 32'(t1_state[k]));
            chk($sformatf("t1_strobes_%0d", k), 32'(strobes), 32'(t1_strb[k]));
            chk($sformatf("t1_busy_%0d", k), 32'(busy), 32'd1);
        end
        budget = 100;
        while (sb.size() > 0 && budget > 0) begin
            // Ask to stop once the last instruction has begun fetching.
            if (sb.size() == 1 && state == 3'd1) single_step = 1'b1;
            step();
            budget--;
        end
        chk("freerun_drain", 32'(sb.size()), 32'd0);
        step();
        chk("freerun_idle", 32'(state), 32'd0);
        chk("freerun_busy", 32'(busy), 32'd0);
        chk("freerun_count", instr_count, 32'd10);

        // MEMORY stalled by mem_ready low for four cycles
        mem_ready = 1'b0;
        pulse_start(e);
        sb.push_back('{e + 9, 32'd11});
        mem_cycles = 0;
        while (cyc < e + 10) begin
            if (cyc == e + 8) mem_ready = 1'b1;
            step();
        end
        chk("stall_mem_cycles", 32'(mem_cycles), 32'd5);
        chk("stall_idle", 32'(state), 32'd0);

        // Single step, two pulses
        for (int n = 0; n < 2; n++) begin
            pulse_start(e);
            sb.push_back('{e + 5, 32'(12 + n)});
            repeat (6) step();
            chk($sformatf("ss_idle_%0d", n), 32'(state), 32'd0);
            chk($sformatf("ss_busy_%0d", n), 32'(busy), 32'd0);
        end
        chk("ss_count", instr_count, 32'd13);

        // Reset during EXECUTE abandons the instruction
        pulse_start(e);
        repeat (3) step();
        chk("rexec_in_exec", 32'(state), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rexec_state", 32'(state), 32'd0);
        chk("rexec_count", instr_count, 32'd0);
        chk("rexec_outputs", 32'({strobes, pc_write, busy, halted}), 32'd0);
        repeat (8) step();
        chk("rexec_stays_idle", 32'(state), 32'd0);

        // halt_req during DECODE: instruction retires, then HALT
        single_step = 1'b0;
        pulse_start(e);
        sb.push_back('{e + 5, 32'd1});
        repeat (2) step();
        chk("halt_in_decode", 32'(state), 32'd2);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        repeat (3) step();
        chk("halt_state", 32'(state), 32'd6);
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_busy", 32'(busy), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("halt_ignores_start", 32'(state), 32'd6);
        chk("halt_count", instr_count, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_count", instr_count, 32'd0);

        // halt_req with start in IDLE goes straight to HALT
        halt_req = 1'b1;
        start    = 1'b1;
        step();
        halt_req = 1'b0;
        start    = 1'b0;
        chk("idle_halt_state", 32'(state), 32'd6);
        chk("idle_halt_halted", 32'(halted), 32'd1);
        repeat (3) step();
        chk("idle_halt_absorb", 32'(state), 32'd6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("final_idle", 32'(state), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
